serial_word_packer: RTL

SERIAL_WORD_PACKER -- requirements
Module: serial_word_packer

---
 rtl/palindrome_pkg.sv | 13 +
 rtl/serial_word_packer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/palindrome_pkg.sv
// Shared types and constants for the palindrome datapath: default word length
// and the serial packer state encoding.
package palindrome_pkg;

    localparam int unsigned PALINDROME_LEN = 4;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } packer_state_t;

endpackage

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream MSB-first into WORD_LEN-bit words with a double buffer.
// Optional macro PACKER_PARITY_EN adds o_word_parity, registered alongside o_word.
module serial_word_packer
    import palindrome_pkg::*;
#(
    parameter int unsigned WORD_LEN = PALINDROME_LEN
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_bit,
    input  logic                i_bit_valid,
    output logic                o_bit_ready,
    input  logic                i_flush,
    output logic [WORD_LEN-1:0] o_word,
    output logic                o_word_valid,
    input  logic                i_word_ready,
    output logic [15:0]         o_word_cnt
`ifdef PACKER_PARITY_EN
    ,
    output logic                o_word_parity
`endif
);

    localparam int unsigned CNT_W = $clog2(WORD_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_LEN - 1);

    packer_state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_LEN-2:0] shift_q, shift_d;
    logic [WORD_LEN-1:0] word_q, word_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [WORD_LEN-1:0] new_word;

    logic word_valid;
    logic bit_ready;
    logic accept;
    logic last_bit;
    logic deliver;

    // State register and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Datapath next-state: shift register, bit counter, output word, delivery count
    always_comb begin
        accept     = i_bit_valid && bit_ready && !i_flush;
        last_bit   = accept && (cnt_q == LAST_IDX);
        deliver    = word_valid && i_word_ready;
        new_word   = {shift_q, i_bit};

        cnt_d      = cnt_q;
        shift_d    = shift_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;

        if (i_flush) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (accept) begin
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
            shift_d = new_word[WORD_LEN-2:0];
        end

        if (last_bit) begin
            word_d = new_word;
        end
        if (deliver) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    // Next-state: a load keeps/sets HOLD even when the old word leaves this cycle
    always_comb begin
        state_d = state_q;
        if (last_bit || (word_valid && !deliver)) begin
            state_d = HOLD;
        end else if (cnt_d != '0) begin
            state_d = COLLECT;
        end else begin
            state_d = IDLE;
        end
    end

    // Outputs: stall only when the last bit would overwrite an unaccepted word
    always_comb begin
        word_valid   = (state_q == HOLD);
        bit_ready    = !i_rst && !((cnt_q == LAST_IDX) && word_valid && !i_word_ready);
        o_bit_ready  = bit_ready;
        o_word_valid = word_valid;
        o_word       = word_q;
        o_word_cnt   = word_cnt_q;
    end

`ifdef PACKER_PARITY_EN
    logic parity_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            parity_q <= 1'b0;
        end else if (last_bit) begin
            parity_q <= ^new_word;
        end
    end

    assign o_word_parity = parity_q;
`endif

endmodule
